// File: rtl/tmds_decoder_10b8b.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder_10b8b
// Purpose  : TMDS channel decoder with control-token word-alignment FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_decoder_10b8b #(
    parameter int CTRL_RUN     = 8,
    parameter int SEARCH_WIN   = 4096,
    parameter int SLIP_WAIT    = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_sym,
    input  logic       i_sym_valid,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_valid,
    output logic       o_aligned,
    output logic       o_bitslip
);

    localparam int MAX_AB = (CTRL_RUN > SEARCH_WIN) ? CTRL_RUN : SEARCH_WIN;
    localparam int MAX_CD = (SLIP_WAIT > LOCK_TIMEOUT) ? SLIP_WAIT : LOCK_TIMEOUT;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          de_q, de_d;
    logic          valid_q, valid_d;
    logic          bitslip_q, bitslip_d;

    logic          is_ctrl;
    logic [1:0]    tok;
    logic [7:0]    d_raw;
    logic [7:0]    dec;
    logic          run_hit;
    logic          run_sat;

    always_comb begin
        is_ctrl = 1'b1;
        tok     = 2'b00;
        case (i_sym)
            10'h354: tok = 2'b00;
            10'h0AB: tok = 2'b01;
            10'h154: tok = 2'b10;
            10'h2AB: tok = 2'b11;
            default: is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        d_raw  = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];
        dec    = '0;
        dec[0] = d_raw[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = i_sym[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
        end
    end

    assign run_hit = is_ctrl && (run_q == CW'(CTRL_RUN - 1));
    assign run_sat = (run_q == CW'(CTRL_RUN));

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        win_d     = win_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        de_d      = de_q;
        valid_d   = i_sym_valid;
        bitslip_d = 1'b0;

        if (i_sym_valid) begin
            de_d = ~is_ctrl;
            if (is_ctrl) begin
                ctrl_d = tok;
            end else begin
                data_d = dec;
            end

            if (is_ctrl) begin
                if (!run_sat) begin
                    run_d = run_q + 1'b1;
                end
            end else begin
                run_d = '0;
            end

            case (state_q)
                ST_SEARCH: begin
                    // A run hit takes priority over window expiry.
                    if (run_hit) begin
                        state_d = ST_LOCKED;
                        win_d   = '0;
                        tmo_d   = '0;
                    end else if (win_q == CW'(SEARCH_WIN - 1)) begin
                        state_d   = ST_SLIP;
                        bitslip_d = 1'b1;
                        win_d     = '0;
                        run_d     = '0;
                        settle_d  = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
                ST_SLIP: begin
                    run_d = '0;
                    if (settle_q == CW'(SLIP_WAIT - 1)) begin
                        state_d  = ST_SEARCH;
                        settle_d = '0;
                        win_d    = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (run_hit || (is_ctrl && run_sat)) begin
                        tmo_d = '0;
                    end else if (tmo_q == CW'(LOCK_TIMEOUT - 1)) begin
                        state_d = ST_SEARCH;
                        tmo_d   = '0;
                        run_d   = '0;
                        win_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            win_q     <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
            de_q      <= 1'b0;
            valid_q   <= 1'b0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            win_q     <= win_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            de_q      <= de_d;
            valid_q   <= valid_d;
            bitslip_q <= bitslip_d;
        end
    end

    assign o_data    = data_q;
    assign o_ctrl    = ctrl_q;
    assign o_de      = de_q;
    assign o_valid   = valid_q;
    assign o_aligned = (state_q == ST_LOCKED);
    assign o_bitslip = bitslip_q;

endmodule
`default_nettype wire
